// File: rtl/seq_det_sched_pkg.sv
// Shared types for the round-robin "101" detector scheduler.
// Consumers: seq_det_sched (top) and seq101_core (detector).
package seq_det_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } sched_state_e;

    // Detector state is {A, B}: A = "10" seen, B = last bit was 1.
    localparam int              DET_W     = 2;
    localparam logic [DET_W-1:0] DET_RESET = 2'b00;

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester/result bundle between producers and the seq_det_sched scheduler.
interface seq_det_sched_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_cnt;

    modport master (
        output req, word,
        input  gnt, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req, word,
        output gnt, busy, done, done_id, match_cnt
    );

endinterface

// File: rtl/seq_det_sched_core.sv
// seq101_core: 2-flop overlapping Mealy "101" detector with synchronous clear.
module seq101_core
    import seq_det_sched_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic x,
    output logic z
);

    logic [DET_W-1:0] det_q, det_d;

    always_comb begin
        det_d = {det_q[0] & ~x, x};
        if (clr) begin
            det_d = DET_RESET;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            det_q <= DET_RESET;
        end else begin
            det_q <= det_d;
        end
    end

    assign z = det_q[1] & x;

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler feeding requester words MSB-first into one "101" detector.
// Optional macro SEQ_DET_SCHED_FIRST_HIT_EN: stop shifting at the first match.
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    seq_det_sched_if.slave bus
);

    localparam int ID_W = $clog2(NREQ);
    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
    localparam bit FIRST_HIT = 1'b1;
`else
    localparam bit FIRST_HIT = 1'b0;
`endif

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [ID_W-1:0]   winner, cand;
    logic              found;
    logic              det_clr, det_x, det_z;

    seq101_core u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (det_clr),
        .x       (det_x),
        .z       (det_z)
    );

    assign det_x = shreg_q[WORD_W-1];

    // Round-robin search starting at the pointer, wrapping past NREQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ID_W'((32'(rr_q) + i) % NREQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign cnt_inc = (det_z && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        win_d     = win_q;
        done_id_d = done_id_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        det_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    det_clr  = 1'b1;
                    shreg_d  = bus.word[winner*WORD_W +: WORD_W];
                    bitcnt_d = BC_W'(WORD_W - 1);
                    cnt_d    = '0;
                    win_d    = winner;
                    rr_d     = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q - 1'b1;
                cnt_d    = cnt_inc;
                if (bitcnt_q == '0 || (FIRST_HIT && det_z)) begin
                    match_d   = cnt_inc;
                    done_id_d = win_q;
                    state_d   = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            done_id_q <= '0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            match_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            done_id_q <= done_id_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
        end
    end

    // Grant is combinational so the word is captured in the same cycle; reset masks it.
    assign bus.gnt       = (state_q == IDLE && found && reset_n) ? (NREQ'(1) << winner) : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == REPORT);
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = match_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: predicted results queued at grant, checked on done.
module tb_seq_det_sched;

    localparam int NREQ   = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    typedef struct {
        int id;
        int cnt;
        int lat;
        int gcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    exp_t exp_q[$];
    int   rr_m = 0;
    bit   have_prev = 1'b0;
    int   prev_gcyc = 0;
    int   prev_lat = 0;

    seq_det_sched_if #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    seq_det_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: scan the word MSB-first for overlapping "101" patterns.
    function automatic void ref_eval(input logic [WORD_W-1:0] w, output int cnt, output int lat);
        int hits = 0;
        int first = 0;
        for (int j = 2; j < WORD_W; j++) begin
            if (w[WORD_W-1-(j-2)] && !w[WORD_W-1-(j-1)] && w[WORD_W-1-j]) begin
                hits++;
                if (first == 0) first = j + 1;
            end
        end
`ifdef SEQ_DET_SCHED_FIRST_HIT_EN
        cnt = (first != 0) ? 1 : 0;
        lat = (first != 0) ? first + 1 : WORD_W + 1;
`else
        cnt = (hits > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : hits;
        lat = WORD_W + 1;
`endif
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(rr + i) % NREQ]) return (rr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*WORD_W-1:0] rand_words();
        logic [NREQ*WORD_W-1:0] w;
        for (int i = 0; i < NREQ; i++) w[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        return w;
    endfunction

    // Present a request set, wait for the grant, check it, queue the expected result.
    task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ*WORD_W-1:0] w);
        int   win, cnt, lat;
        bit   seen = 1'b0;
        exp_t e;
        bus.req  = r;
        bus.word = w;
        #1;
        for (int n = 0; n < 60; n++) begin
            if (bus.gnt != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!seen) begin
            check("gnt_timeout", 0, 1);
            have_prev = 1'b0;
            return;
        end
        win = pick(r, rr_m);
        check("gnt", bus.gnt, longint'(1) << win);
        check("busy_at_gnt", bus.busy, 0);
        if (have_prev) check("gnt_gap", cyc - prev_gcyc, prev_lat + 1);
        ref_eval(w[win*WORD_W +: WORD_W], cnt, lat);
        e.id = win;
        e.cnt = cnt;
        e.lat = lat;
        e.gcyc = cyc;
        exp_q.push_back(e);
        rr_m = (win + 1) % NREQ;
        have_prev = 1'b1;
        prev_gcyc = cyc;
        prev_lat = lat;
        @(negedge clk);
        #1;
    endtask

    task automatic with_slice(input int idx, input logic [WORD_W-1:0] v, output logic [NREQ*WORD_W-1:0] w);
        w = rand_words();
        w[idx*WORD_W +: WORD_W] = v;
    endtask

    // Monitor: every done must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_id", bus.done_id, e.id);
                    check("match_cnt", bus.match_cnt, e.cnt);
                    check("done_latency", cyc - e.gcyc, e.lat);
                    check("busy_at_done", bus.busy, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ*WORD_W-1:0] w;
        bus.req  = '0;
        bus.word = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_done_id", bus.done_id, 0);
        check("rst_match_cnt", bus.match_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full load: every requester asserted, expect strict rotation.
        for (int k = 0; k < 5; k++) do_txn('1, rand_words());

        with_slice(0, 8'b1010_1010, w); do_txn(4'b0001, w);
        with_slice(0, 8'hFF, w);        do_txn(4'b0001, w);
        with_slice(0, 8'h00, w);        do_txn(4'b0001, w);
        with_slice(0, 8'b0101_0101, w); do_txn(4'b0001, w);
        with_slice(0, 8'b1010_0000, w); do_txn(4'b0001, w);

        // No match may straddle two consecutive words from the same requester.
        with_slice(1, 8'b0000_0010, w); do_txn(4'b0010, w);
        with_slice(1, 8'b1000_0000, w); do_txn(4'b0010, w);

        // Reset in the middle of SHIFT: the word is dropped and the pointer cleared.
        with_slice(1, 8'b1010_1010, w); do_txn(4'b0010, w);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        rr_m = 0;
        have_prev = 1'b0;
        check("midrst_gnt", bus.gnt, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_match_cnt", bus.match_cnt, 0);
        check("midrst_done_id", bus.done_id, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn(4'b0110, rand_words());

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.req = '0;
                repeat ($urandom_range(1, 14)) @(negedge clk);
                #1;
                check("idle_gnt", bus.gnt, 0);
                have_prev = 1'b0;
            end
            do_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), rand_words());
        end

        bus.req = '0;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
